// File: rtl/codec_cfg_sequencer.sv
// Power-up configuration sequencer for the audio codec: walks a fixed 12-entry
// register table over the shared I2C master, retrying NACKed writes.
module codec_cfg_sequencer #(
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter logic [15:0] GAP_CYCLES  = 16'd256,
    parameter logic [1:0]  MAX_RETRIES = 2'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        i2c_req,
    output logic [6:0]  i2c_dev_addr,
    output logic [15:0] i2c_word,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  step
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [3:0] LAST_IDX    = 4'd11;
    localparam logic [3:0] NUM_ENTRIES = 4'd12;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  idx_r;
    logic [3:0]  idx_s;
    logic [1:0]  retry_r;
    logic [1:0]  retry_s;
    logic [15:0] gap_r;
    logic [15:0] gap_s;
    logic        req_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;
    logic [3:0]  step_r;
    logic [15:0] word_r;

    // Codec control word {reg_addr[6:0], value[8:0]} for each table entry.
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        case (idx)
            4'd0:    table_word = {7'h0F, 9'h000};
            4'd1:    table_word = {7'h06, 9'h010};
            4'd2:    table_word = {7'h00, 9'h017};
            4'd3:    table_word = {7'h01, 9'h017};
            4'd4:    table_word = {7'h02, 9'h079};
            4'd5:    table_word = {7'h03, 9'h079};
            4'd6:    table_word = {7'h04, 9'h012};
            4'd7:    table_word = {7'h05, 9'h000};
            4'd8:    table_word = {7'h07, 9'h002};
            4'd9:    table_word = {7'h08, 9'h000};
            4'd10:   table_word = {7'h09, 9'h001};
            4'd11:   table_word = {7'h06, 9'h000};
            default: table_word = 16'h0000;
        endcase
    endfunction

    // Next-state, table index, retry and gap-counter logic.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        retry_s = retry_r;
        gap_s   = gap_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_s = S_ISSUE;
                    idx_s   = 4'd0;
                    retry_s = 2'd0;
                end else begin
                    state_s = state_r;
                end
            end
            S_ISSUE: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                if (i2c_done) begin
                    gap_s = 16'd0;
                    if (!i2c_nack) begin
                        idx_s   = idx_r + 4'd1;
                        retry_s = 2'd0;
                        state_s = S_GAP;
                    end else if (retry_r == MAX_RETRIES) begin
                        state_s = S_ERROR;
                    end else begin
                        retry_s = retry_r + 2'd1;
                        state_s = S_GAP;
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_GAP: begin
                if (gap_r == GAP_CYCLES - 16'd1) begin
                    if (idx_r == NUM_ENTRIES) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_ISSUE;
                    end
                end else begin
                    gap_s = gap_r + 16'd1;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register plus outputs registered from the next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            idx_r   <= 4'd0;
            retry_r <= 2'd0;
            gap_r   <= 16'd0;
            req_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            step_r  <= 4'd0;
            word_r  <= table_word(4'd0);
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            retry_r <= retry_s;
            gap_r   <= gap_s;
            req_r   <= (state_s == S_ISSUE);
            busy_r  <= (state_s == S_ISSUE) || (state_s == S_WAIT) || (state_s == S_GAP);
            done_r  <= (state_s == S_DONE);
            error_r <= (state_s == S_ERROR);
            step_r  <= (idx_s > LAST_IDX) ? LAST_IDX : idx_s;
            word_r  <= table_word(idx_s);
        end
    end

    assign i2c_req      = req_r;
    assign i2c_dev_addr = DEV_ADDR;
    assign i2c_word     = word_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign step         = step_r;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Scoreboard bench for codec_cfg_sequencer: an I2C responder model, a table-level
// reference model that predicts every request word/cycle, and a request monitor.
module tb_codec_cfg_sequencer;

    localparam int GAP  = 256;
    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        i2c_req;
    logic [6:0]  i2c_dev_addr;
    logic [15:0] i2c_word;
    logic        i2c_done;
    logic        i2c_nack;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  step;

    int cyc      = 0;
    int n_cmp    = 0;
    int n_bad    = 0;
    int lat      = 20;
    bit spur_en  = 1'b0;
    int req_seen = 0;

    bit resp_plan[$];
    int exp_word_q[$];
    int exp_cyc_q[$];

    int tbl_addr[12] = '{'h0F, 'h06, 'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h07, 'h08, 'h09, 'h06};
    int tbl_val[12]  = '{'h000, 'h010, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h002, 'h000, 'h001, 'h000};

    codec_cfg_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .i2c_req      (i2c_req),
        .i2c_dev_addr (i2c_dev_addr),
        .i2c_word     (i2c_word),
        .i2c_done     (i2c_done),
        .i2c_nack     (i2c_nack),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .step         (step)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: predicts each request (word, cycle) and the final outcome.
    task automatic model(input int start_cyc, input bit plan[$],
                         output int end_cyc, output bit exp_err, output int exp_step);
        int t;
        int a;
        int tries;
        bit nk;
        t        = start_cyc + 1;
        a        = 0;
        exp_err  = 1'b0;
        exp_step = 11;
        end_cyc  = 0;
        for (int e = 0; e < 12; e++) begin
            if (!exp_err) begin
                tries = 0;
                while (1) begin
                    nk = (a < plan.size()) ? plan[a] : 1'b0;
                    a++;
                    exp_word_q.push_back(tbl_addr[e] * 512 + tbl_val[e]);
                    exp_cyc_q.push_back(t);
                    if (nk && tries == MAXR) begin
                        exp_err  = 1'b1;
                        exp_step = e;
                        end_cyc  = t + lat + 1;
                        break;
                    end
                    t += lat + 1 + GAP;
                    if (!nk) break;
                    tries++;
                end
            end
        end
        if (!exp_err) end_cyc = t;
    endtask

    // Request monitor: every i2c_req pulse must match the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        if (i2c_req === 1'b1) begin
            req_seen++;
            if (exp_word_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_req: got word %0h, expected no request (cycle %0d)",
                         i2c_word, cyc);
            end else begin
                check("req_word", int'(i2c_word), exp_word_q.pop_front());
                check("req_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    // I2C master model: done after lat cycles, optional spurious done/nack pulses.
    initial begin
        int due;
        int spur_at;
        bit pend;
        due      = 0;
        spur_at  = -1;
        pend     = 1'b0;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (reset === 1'b1) begin
                pend    = 1'b0;
                spur_at = -1;
            end else begin
                if (pend && cyc == due) begin
                    pend     = 1'b0;
                    i2c_done = 1'b1;
                    i2c_nack = (resp_plan.size() > 0) ? resp_plan.pop_front() : 1'b0;
                    if (spur_en) spur_at = cyc + int'($urandom_range(2, 200));
                end else if (spur_en && cyc == spur_at) begin
                    i2c_done = 1'b1;
                    i2c_nack = 1'($urandom_range(0, 1));
                    spur_at  = -1;
                end else if (spur_en && pend && cyc == due - lat + 3) begin
                    i2c_nack = 1'b1;
                end
                if (i2c_req === 1'b1) begin
                    pend = 1'b1;
                    due  = cyc + lat;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   int'(i2c_req), 0);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_done"},  int'(done), 0);
        check({tag, "_error"}, int'(error), 0);
        check({tag, "_step"},  int'(step), 0);
        check({tag, "_word"},  int'(i2c_word), 'h1E00);
        check({tag, "_addr"},  int'(i2c_dev_addr), 'h1A);
    endtask

    // One full sequence: called right after a negedge.
    task automatic run_seq(input int l, input bit plan[$], input bit hold_start, input bit spur);
        int end_cyc;
        int st;
        int got;
        bit e_err;
        lat       = l;
        spur_en   = spur;
        resp_plan = plan;
        model(cyc, plan, end_cyc, e_err, st);
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        got = -1;
        for (int i = 0; i < 20000; i++) begin
            if (hold_start && cyc == end_cyc - 5) start = 1'b0;
            if (done || error) begin
                got = cyc;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("end_cycle", got, end_cyc);
        check("done",  int'(done), int'(!e_err));
        check("error", int'(error), int'(e_err));
        check("busy",  int'(busy), 0);
        check("step",  int'(step), st);
        repeat (300) @(negedge clk);
        check("missing_reqs", exp_word_q.size(), 0);
        check("still_done",  int'(done), int'(!e_err));
        exp_word_q.delete();
        exp_cyc_q.delete();
        resp_plan.delete();
        spur_en = 1'b0;
    endtask

    initial begin
        bit p[$];
        int base;
        int d_end;
        bit d_err;
        int d_st;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        p.delete();
        run_seq(20, p, 1'b0, 1'b0);                     // nominal

        p.delete();
        repeat (4) p.push_back(1'b0);
        p.push_back(1'b1);
        run_seq(20, p, 1'b0, 1'b0);                     // restart from DONE, single NACK on entry 4

        p.delete();
        repeat (7) p.push_back(1'b0);
        repeat (4) p.push_back(1'b1);
        run_seq(20, p, 1'b0, 1'b0);                     // persistent NACK on entry 7

        p.delete();
        run_seq(int'($urandom_range(1, 30)), p, 1'b0, 1'b0);  // restart from ERROR

        p.delete();
        run_seq(20, p, 1'b1, 1'b1);                     // start held, spurious done/nack

        // Reset during WAIT of entry 5.
        p.delete();
        lat       = 20;
        resp_plan.delete();
        base      = req_seen;
        model(cyc, p, d_end, d_err, d_st);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5000 && req_seen < base + 6; i++) @(negedge clk);
        check("reach_entry5", req_seen - base, 6);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        exp_word_q.delete();
        exp_cyc_q.delete();
        repeat (40) @(negedge clk);
        check("idle_after_rst_busy", int'(busy), 0);
        run_seq(20, p, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            p.delete();
            for (int k = 0; k < 60; k++) p.push_back($urandom_range(0, 5) == 0);
            run_seq(int'($urandom_range(1, 30)), p, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
